// File: rtl/hex_str_parser.sv
// Streaming ASCII hex parser: folds each run of hex digits into one WIDTH-bit token.
// Define HEX_PARSER_UPPER_EN to also accept 'A'..'F' as digits.
module hex_str_parser #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value,
  output logic [CNT_W-1:0] out_digits,
  output logic             out_ovf,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(WIDTH / 4);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic       is_digit;
  logic [3:0] digit;
  logic       accept;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    if (in_char >= 8'h30 && in_char <= 8'h39) begin
      is_digit = 1'b1;
      digit    = in_char[3:0];
    end else if (in_char >= 8'h61 && in_char <= 8'h66) begin
      is_digit = 1'b1;
      digit    = in_char[3:0] + 4'd9;
    end
`ifdef HEX_PARSER_UPPER_EN
    else if (in_char >= 8'h41 && in_char <= 8'h46) begin
      is_digit = 1'b1;
      digit    = in_char[3:0] + 4'd9;
    end
`endif
  end

  // in_ready depends only on state so the source never sees a path from out_ready.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_digits <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_digit) begin
            acc   <= WIDTH'(digit);
            cnt   <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            if (is_digit) begin
              // Shifting out the top nibble keeps the most recent WIDTH/4 digits.
              acc <= (acc << 4) | WIDTH'(digit);
              if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
              if (cnt >= MAX_DIGITS) ovf <= 1'b1;
            end else begin
              out_value  <= acc;
              out_digits <= cnt;
              out_ovf    <= ovf;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_str_parser.sv
// Directed bench for hex_str_parser: a WIDTH=32 and a WIDTH=16 instance share one stream.
`timescale 1ns/1ps
module tb_hex_str_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h20;
  logic        out_ready = 1'b1;
  logic        in_ready, in_ready16;
  logic        out_valid, out_valid16;
  logic [31:0] out_value;
  logic [15:0] out_value16;
  logic [4:0]  out_digits, out_digits16;
  logic        out_ovf, out_ovf16;

  hex_str_parser #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .out_valid(out_valid), .out_value(out_value),
    .out_digits(out_digits), .out_ovf(out_ovf), .out_ready(out_ready)
  );

  hex_str_parser #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready16), .out_valid(out_valid16), .out_value(out_value16),
    .out_digits(out_digits16), .out_ovf(out_ovf16), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] v;
    logic [7:0]  d;
    logic        o;
  } tok_t;

  tok_t tok32[256];
  tok_t tok16[256];
  int   wr32 = 0, wr16 = 0, rd32 = 0, rd16 = 0;
  int   low_cnt = 0;
  int   vectors = 0, errors = 0;

  // Token handshakes are logged from the pre-edge values at the accepting edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        tok32[wr32 % 256] = '{v: 64'(out_value), d: 8'(out_digits), o: out_ovf};
        wr32++;
      end
      if (out_valid16 && out_ready) begin
        tok16[wr16 % 256] = '{v: 64'(out_value16), d: 8'(out_digits16), o: out_ovf16};
        wr16++;
      end
      if (!in_ready) low_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic expect_tok(input string tag, input logic [63:0] v32, input logic [63:0] v16,
                            input int d, input logic o32, input logic o16);
    check({tag, "_cnt32"}, 64'(wr32 > rd32), 64'd1);
    check({tag, "_cnt16"}, 64'(wr16 > rd16), 64'd1);
    if (wr32 > rd32) begin
      check({tag, "_val32"}, tok32[rd32 % 256].v, v32);
      check({tag, "_dig32"}, 64'(tok32[rd32 % 256].d), 64'(d));
      check({tag, "_ovf32"}, 64'(tok32[rd32 % 256].o), 64'(o32));
      rd32++;
    end
    if (wr16 > rd16) begin
      check({tag, "_val16"}, tok16[rd16 % 256].v, v16);
      check({tag, "_ovf16"}, 64'(tok16[rd16 % 256].o), 64'(o16));
      rd16++;
    end
  endtask

  task automatic expect_none(input string tag);
    check(tag, 64'(wr32 - rd32), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    low0;
    string sat;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_value", 64'(out_value), 64'd0);
    check("rst_out_digits", 64'(out_digits), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic run with a single HOLD bubble.
    low0 = low_cnt;
    send_str("1f3 ");
    repeat (4) @(negedge clk);
    check("basic_ready_low", 64'(low_cnt - low0), 64'd1);
    expect_tok("basic", 64'h1F3, 64'h1F3, 3, 1'b0, 1'b0);
    expect_none("basic_extra");

    // Leading and repeated delimiters produce no empty tokens.
    send_str("  ,ab\n\n7;");
    repeat (3) @(negedge clk);
    expect_tok("skip_ab", 64'hAB, 64'hAB, 2, 1'b0, 1'b0);
    expect_tok("skip_7", 64'h7, 64'h7, 1, 1'b0, 1'b0);
    expect_none("skip_extra");

    // Overflow only in the 16-bit instance; exactly WIDTH/4 digits is not overflow.
    send_str("123456 ");
    send_str("ffff ");
    repeat (3) @(negedge clk);
    expect_tok("ovf_123456", 64'h123456, 64'h3456, 6, 1'b0, 1'b1);
    expect_tok("ovf_ffff", 64'hFFFF, 64'hFFFF, 4, 1'b0, 1'b0);

    // 33 digits: the counter saturates at 31 and both widths overflow.
    sat = "";
    for (int i = 0; i < 33; i++) sat = {sat, "1"};
    send_str({sat, " "});
    repeat (3) @(negedge clk);
    expect_tok("sat", 64'h11111111, 64'h1111, 31, 1'b1, 1'b1);

    // Decode boundaries: '/', ':', '`', 'g' are delimiters.
    send_str("/0:9`a`f g");
    repeat (3) @(negedge clk);
    expect_tok("bnd_0", 64'h0, 64'h0, 1, 1'b0, 1'b0);
    expect_tok("bnd_9", 64'h9, 64'h9, 1, 1'b0, 1'b0);
    expect_tok("bnd_a", 64'hA, 64'hA, 1, 1'b0, 1'b0);
    expect_tok("bnd_f", 64'hF, 64'hF, 1, 1'b0, 1'b0);
    expect_none("bnd_extra");

    // Back-pressure: token held stable, held source char accepted after the handshake.
    out_ready = 1'b0;
    send_str("9 ");
    in_char  = "8";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_value", 64'(out_value), 64'h9);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", 64'(in_ready), 64'd1);
    check("bp_valid_after", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    send_str(" ");
    repeat (3) @(negedge clk);
    expect_tok("bp_9", 64'h9, 64'h9, 1, 1'b0, 1'b0);
    expect_tok("bp_8", 64'h8, 64'h8, 1, 1'b0, 1'b0);
    expect_none("bp_extra");

    // Asynchronous reset mid-run clears outputs at once and drops the partial token.
    send_str("12");
    #2 reset = 1'b1;
    #1;
    check("rstmid_out_value", 64'(out_value), 64'd0);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_out_digits", 64'(out_digits), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    send_str("5 ");
    repeat (3) @(negedge clk);
    expect_tok("rstmid_5", 64'h5, 64'h5, 1, 1'b0, 1'b0);
    expect_none("rstmid_extra");

    // Upper-case digits depend on the build option.
    send_str("1A2 ");
    send_str("Fe ");
    repeat (3) @(negedge clk);
`ifdef HEX_PARSER_UPPER_EN
    expect_tok("upper_1a2", 64'h1A2, 64'h1A2, 3, 1'b0, 1'b0);
    expect_tok("upper_fe", 64'hFE, 64'hFE, 2, 1'b0, 1'b0);
`else
    expect_tok("upper_1", 64'h1, 64'h1, 1, 1'b0, 1'b0);
    expect_tok("upper_2", 64'h2, 64'h2, 1, 1'b0, 1'b0);
    expect_tok("upper_e", 64'hE, 64'hE, 1, 1'b0, 1'b0);
`endif
    expect_none("upper_extra");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hex_str_parser.md
# hex_str_parser

Streaming ASCII-to-binary hex number parser. Consumes one 8-bit character per accepted handshake, accumulates consecutive hex digits into a WIDTH-bit value and emits one result token per digit run. A run ends on a non-digit delimiter. It sits between a byte-stream source (UART RX / test input FIFO) and any consumer that needs binary operands, and generalises single-character hex decoding to multi-digit, back-pressured streams.

## Interface
Parameters:
- WIDTH, 32, result width in bits; must be a multiple of 4, range 4..64.
- CNT_W, 5, width of the digit counter; must satisfy 2^CNT_W > WIDTH/4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_char holds a character.
- in_char  input  8  ASCII character.
- in_ready  output  1  parser accepts in_char this cycle.
- out_valid  output  1  result token available.
- out_value  output  WIDTH  parsed value.
- out_digits  output  CNT_W  number of digits in the run, saturating at 2^CNT_W-1.
- out_ovf  output  1  run had more than WIDTH/4 digits.
- out_ready  input  1  consumer takes the token this cycle.

## Operation
- Digit decode: '0'..'9' (0x30..0x39) map to 0..9. 'a'..'f' (0x61..0x66) map to 10..15. Every other byte is a delimiter.
- A char is accepted when in_valid && in_ready.
- State IDLE:
  - in_ready=1.
  - Accepted digit: acc <= digit, cnt <= 1, ovf <= 0, go to ACC.
  - Accepted delimiter: dropped, so leading and repeated delimiters are skipped.
- State ACC:
  - in_ready=1.
  - Accepted digit: acc <= {acc[WIDTH-5:0], digit}, cnt <= cnt+1 (saturating).
  - If cnt was already >= WIDTH/4 before this digit, also set ovf <= 1. acc keeps the low WIDTH bits, so the last WIDTH/4 digits win.
  - Accepted delimiter: copy acc/cnt/ovf to the output registers and go to HOLD. The delimiter is consumed, not replayed.
- State HOLD:
  - in_ready=0 and out_valid=1.
  - out_value, out_digits and out_ovf stay stable until out_valid && out_ready, then go to IDLE.
- The end of the stream is marked only by a delimiter. A trailing run with no delimiter stays in ACC indefinitely.
- Reset clears the state to IDLE and clears acc, cnt, ovf, out_valid, out_value, out_digits and out_ovf to 0. in_ready is 1 after reset. A reset mid-run discards the partial token.

## Timing
- All outputs are registered except in_ready, which is decoded from the state: in_ready = (state != HOLD).
- Latency: the delimiter is accepted at edge N and out_valid=1 from edge N.
- A token handshake at edge M puts the parser in IDLE with in_ready=1 from edge M. in_ready never depends combinationally on out_ready; this costs one bubble cycle per token.
- An N-digit run plus its delimiter takes N+1 accepted cycles, plus at least 1 HOLD cycle.
- in_valid low in any state causes no state change. Gaps are allowed mid-run.
- in_valid while in HOLD is ignored: in_ready=0 and the source must hold in_char.
- out_ready outside HOLD is ignored.

## Configuration
- HEX_PARSER_UPPER_EN defined:
  - 'A'..'F' (0x41..0x46) are also digits, mapping to 10..15.
  - Mixed case within one run is legal.
- Not defined:
  - 'A'..'F' are delimiters.
  - "1A" therefore yields token 0x1 with out_digits=1, then 'A' is consumed as its delimiter.

## Test plan
- Basic run, WIDTH=32, out_ready=1: stream "1f3 " -> one token, out_value=0x1F3, out_digits=3, out_ovf=0; in_ready low exactly 1 cycle.
- Delimiter skipping: stream "  ,ab\n\n7;" -> tokens 0xAB (digits=2) then 0x7 (digits=1), and no empty tokens.
- Overflow, WIDTH=16: "123456 " -> out_value=0x3456, out_digits=6, out_ovf=1. "ffff " -> 0xFFFF, out_ovf=0.
- Back-pressure: out_ready=0 for 5 cycles after "9 " while the source holds '8' valid -> in_ready=0 and out_value=0x9 stable throughout. Raising out_ready completes the handshake, then '8' is accepted the next cycle.
- Reset mid-run: "12" accepted, then reset pulsed asynchronously between edges -> outputs 0 immediately and in_ready=1. Then "5 " -> token 0x5, digits=1.
- Macro: "Fe " -> with HEX_PARSER_UPPER_EN, 0xFE with digits=2. Without it, a single token 0xE with digits=1, because 'F' is a skipped delimiter.
